// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side drain engine.
// Default data width, minimum output buffer depth and pointer sizing.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int MIN_BUF_DEPTH = 3;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream of the FIFO drain engine.
// The engine drives the master side, the sink uses the slave side.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/fifo_rd_stream_buf.sv
// Small circular register buffer: push at tail, pop at head.
// Exposes occupancy and the head word; push/pop may coincide.
module stream_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = MIN_BUF_DEPTH,
    localparam int PW   = ptr_w(DEPTH),
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [OW-1:0]    occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? nxt(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        unique case (1'b1)
            (push_i && !pop_i): occ_d = occ_q + 1'b1;
            (pop_i && !push_i): occ_d = occ_q - 1'b1;
            default:            occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a registered-read sync FIFO into a valid/ready stream.
// Reads are only issued when the buffer can take the returning word.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BUF_DEPTH = MIN_BUF_DEPTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 fifo_rd_en,
    fifo_rd_stream_if.master     m,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic                 idle
);

    localparam int OW = $clog2(BUF_DEPTH + 1);

    logic [OW-1:0]        occ;
    logic [WIDTH-1:0]     head;
    logic                 pop;
    logic [OW:0]          budget;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Reserve a slot for the word still coming back from the FIFO.
    assign budget = {1'b0, occ} + {{OW{1'b0}}, inflight_q};

    assign fifo_rd_en = res_n && enable && !fifo_empty
                        && (budget < (OW + 1)'(BUF_DEPTH));

    assign m.m_valid = (occ != '0);
    assign m.m_data  = head;
    assign pop       = m.m_valid && m.m_ready;

    always_comb begin
        inflight_d = fifo_rd_en;
        cnt_d      = cnt_q + CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .res_n       (res_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_rdata),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

    assign word_cnt = cnt_q;
    assign idle     = (occ == '0) && !inflight_q;

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the team's synchronous FIFO. It drives the FIFO's `rd_en`, absorbs the FIFO's one-cycle registered read latency, and presents the popped words as a valid/ready stream to a downstream consumer at full throughput. It never asserts `rd_en` into an empty FIFO, so it never causes underflow. It sits between `sync_fifo` (read port) and any streaming sink.

## Interface
- `WIDTH`, 8: data width; must match the FIFO's `WIDTH`.
- `BUF_DEPTH`, 3: output buffer entries. Minimum 3 for one word per cycle with no combinational `m_ready` to `fifo_rd_en` path.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

Ports:
- `clk`  in  1  rising-edge clock, same clock as the FIFO.
- `res_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  when high, new FIFO reads may be issued.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rdata`  in  WIDTH  FIFO `rdata`; valid the cycle after `fifo_rd_en` was sampled high.
- `fifo_rd_en`  out  1  read request to the FIFO.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  WIDTH  output word, the oldest buffered entry.
- `word_cnt`  out  CNT_WIDTH  number of words delivered, meaning `m_valid && m_ready` handshakes.
- `idle`  out  1  high when the buffer is empty and no read is in flight.

## Operation
- State:
  - buffer `buf[BUF_DEPTH]` with write and read pointers that wrap at `BUF_DEPTH`;
  - occupancy `occ` (0..BUF_DEPTH);
  - 1-bit `inflight` register.
- Issue rule, combinational from registered state only: `fifo_rd_en = res_n && enable && !fifo_empty && (occ + inflight) < BUF_DEPTH`.
- `inflight` is the registered copy of `fifo_rd_en`. When `inflight=1`, `fifo_rdata` is written into `buf` at the write pointer on that edge.
- Pop: on `m_valid && m_ready`, the read pointer advances and `word_cnt` increments. `word_cnt` wraps modulo 2^CNT_WIDTH with no saturation.
- Capture and pop in the same cycle: `occ` is unchanged, and both pointers advance.
- Output signals:
  - `m_valid = (occ != 0)`.
  - `m_data = buf[rd_ptr]`, held stable while `m_valid && !m_ready`, as the AXI-style rule requires.
- Drop of `enable`: no new reads are issued. An in-flight word is still captured, and buffered words are still delivered.
- Output `idle = (occ==0) && !inflight`.
- Order: words leave in exactly FIFO pop order; nothing is dropped or duplicated.

## Timing
- Reset is asynchronous on `res_n` falling. While `res_n` is low:
  - `m_valid=0`, `m_data=0`, `word_cnt=0`, `inflight=0`, `occ=0`, pointers 0, `idle=1`;
  - `fifo_rd_en=0` regardless of `fifo_empty`.
- Release is synchronous in effect: the first read can issue in the first cycle after `res_n` rises.
- Latency:
  - rd_en at edge N leads to capture at edge N+1, with `m_valid` high after edge N+1;
  - the earliest handshake is at edge N+2.
- Throughput: 1 word/cycle sustained when `m_ready=1` and the FIFO is non-empty.
- Buffer full: when `occ + inflight == BUF_DEPTH`, no read is issued. This holds even if `m_ready` is high that cycle; the cost is one bubble, accepted by design.
- `fifo_empty` rising while a read is in flight: the captured word is still valid, because the FIFO updated `rdata` on the issuing edge.
- Reset asserted mid-stream: all buffered and in-flight words are discarded. The FIFO is reset by its own reset in the same event.

## Structure
- Shared package `fifo_pkg` holds the default `WIDTH`, the `BUF_DEPTH` minimum constant, and the pointer width function `$clog2(BUF_DEPTH)`.
- One natural sub-module, `stream_buf`: a small circular register buffer with push, pop, `occ` and head data, instantiated once. The issue logic and counter stay in the top.

## Test plan
- Reset, then FIFO preloaded with 0x11..0x14, `m_ready=1`:
  - `fifo_rd_en` high for 4 consecutive cycles;
  - `m_data` sequence 0x11, 0x12, 0x13, 0x14 on consecutive cycles starting 2 cycles after the first rd_en;
  - `word_cnt=4`, then `idle=1`.
- Backpressure: FIFO holds 10 words, `m_ready=0`:
  - exactly 3 reads issue, then `fifo_rd_en` stays 0;
  - `m_data` holds the first word stable;
  - after `m_ready=1`, all 10 words arrive in order, and the FIFO never sees rd_en while empty (underflow stays 0).
- Random `m_ready` (50%) and random FIFO writes over 1000 words: the scoreboard matches order, `word_cnt=1000`, and FIFO underflow is never set.
- `enable` dropped one cycle after a read issues: the in-flight word is still delivered, no further rd_en occurs, and `idle` goes high after drain.
- Assert `res_n` low with 2 words buffered and one in flight:
  - `m_valid` and `fifo_rd_en` drop immediately (asynchronously);
  - `word_cnt=0`;
  - no stale word appears after release.
- `word_cnt` wrap with `CNT_WIDTH=4`: 17 handshakes give `word_cnt=1`.
